// File: rtl/pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: state encoding and default sizing.
package pattern_tx_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned DEF_GAP_W = 4;

    localparam logic [3:0] DEF_PAT = 4'b1101;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = IDLE,
        StShift = SHIFT,
        StGap   = GAP,
        StDone  = DONE
    } state_e;

endpackage

// File: rtl/ptx_shreg.sv
// Parallel-load, left-shift register with sync clear; exposes the MSB it will hold after
// the coming edge so the parent can register dout in step with the register contents.
module ptx_shreg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb_nxt
);

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;

    // Priority: clear over load over shift.
    always_comb begin
        sh_d = sh_q;
        if (clear) begin
            sh_d = '0;
        end else if (load) begin
            sh_d = din;
        end else if (shift) begin
            sh_d = {sh_q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb_nxt = sh_d[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first, repeated with an
// optional idle gap between repetitions. All outputs are registered.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pat,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             dout,
    output logic             dvalid,
    output logic             sof,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [GAP_W-1:0] gap_reg_q, gap_reg_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] pat_q, pat_d;

    logic             sh_clear, sh_load, sh_shift;
    logic [WIDTH-1:0] sh_din;
    logic             sh_msb_nxt;

    logic dout_d, dvalid_d, sof_d, busy_d, done_d;

    ptx_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (sh_clear),
        .load    (sh_load),
        .shift   (sh_shift),
        .din     (sh_din),
        .msb_nxt (sh_msb_nxt)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        gap_reg_d = gap_reg_q;
        gap_cnt_d = gap_cnt_q;
        pat_d     = pat_q;
        sh_clear  = 1'b0;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_din    = pat_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    pat_d     = pat;
                    sh_din    = pat;
                    sh_load   = 1'b1;
                    rep_cnt_d = (reps == '0) ? CNT_W'(1) : reps;
                    gap_reg_d = gap;
                    bit_cnt_d = LAST_BIT;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (bit_cnt_q != '0) begin
                    sh_shift  = 1'b1;
                    bit_cnt_d = bit_cnt_q - BW'(1);
                end else if (rep_cnt_q <= CNT_W'(1)) begin
                    state_d = StDone;
                end else if (gap_reg_q == '0) begin
                    // Back-to-back frame: reload without leaving SHIFT.
                    sh_load   = 1'b1;
                    bit_cnt_d = LAST_BIT;
                    rep_cnt_d = rep_cnt_q - CNT_W'(1);
                end else begin
                    gap_cnt_d = gap_reg_q;
                    rep_cnt_d = rep_cnt_q - CNT_W'(1);
                    state_d   = StGap;
                end
            end
            StGap: begin
                if (gap_cnt_q <= GAP_W'(1)) begin
                    gap_cnt_d = '0;
                    sh_load   = 1'b1;
                    bit_cnt_d = LAST_BIT;
                    state_d   = StShift;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort && (state_q != StIdle)) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            rep_cnt_d = '0;
            gap_reg_d = '0;
            gap_cnt_d = '0;
            sh_clear  = 1'b1;
            sh_load   = 1'b0;
            sh_shift  = 1'b0;
        end
    end

    // Outputs are decoded from next state so they line up with the state they describe.
    always_comb begin
        dvalid_d = (state_d == StShift);
        dout_d   = dvalid_d & sh_msb_nxt;
        sof_d    = dvalid_d && (bit_cnt_d == LAST_BIT);
        busy_d   = (state_d != StIdle);
        done_d   = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            gap_reg_q <= '0;
            gap_cnt_q <= '0;
            pat_q     <= '0;
            dout      <= 1'b0;
            dvalid    <= 1'b0;
            sof       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            gap_reg_q <= gap_reg_d;
            gap_cnt_q <= gap_cnt_d;
            pat_q     <= pat_d;
            dout      <= dout_d;
            dvalid    <= dvalid_d;
            sof       <= sof_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: queue-based reference model compared every cycle,
// plus literal expectations for the directed frame scenarios.
module tb_pattern_tx;
    import pattern_tx_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned GW = 4;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic          abort;
    logic [W-1:0]  pat;
    logic [CW-1:0] reps;
    logic [GW-1:0] gap;
    logic          dout, dvalid, sof, busy, done;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    // Expected {dout, dvalid, sof, busy, done} for each upcoming non-idle cycle.
    logic [4:0] exp_q[$];

    pattern_tx #(
        .WIDTH (W),
        .CNT_W (CW),
        .GAP_W (GW)
    ) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .start  (start),
        .abort  (abort),
        .pat    (pat),
        .reps   (reps),
        .gap    (gap),
        .dout   (dout),
        .dvalid (dvalid),
        .sof    (sof),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic push_frame(input logic [W-1:0] p, input int r, input int g);
        int n;
        n = (r == 0) ? 1 : r;
        for (int i = 0; i < n; i++) begin
            for (int b = W - 1; b >= 0; b--) begin
                exp_q.push_back({p[b], 1'b1, (b == W - 1), 1'b1, 1'b0});
            end
            if (i != n - 1) begin
                for (int j = 0; j < g; j++) exp_q.push_back(5'b00010);
            end
        end
        exp_q.push_back(5'b00011);
    endtask

    always @(posedge clk) begin
        if (!n_rst) begin
            exp_q.delete();
        end else if (exp_q.size() != 0) begin
            if (abort) exp_q.delete();
            else void'(exp_q.pop_front());
        end else if (start && !abort) begin
            push_frame(pat, int'(reps), int'(gap));
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Advance to the next sampling point and compare the DUT against the model.
    task automatic tick();
        logic [4:0] exp_v;
        logic [4:0] act_v;
        @(negedge clk);
        if (checking) begin
            exp_v = (exp_q.size() != 0) ? exp_q[0] : 5'b00000;
            act_v = {dout, dvalid, sof, busy, done};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_compare: got=%b want=%b (dout,dvalid,sof,busy,done) at %0t",
                         act_v, exp_v, $time);
            end
        end
    endtask

    task automatic run_frame(input logic [W-1:0] p, input logic [CW-1:0] r,
                             input logic [GW-1:0] g, input bit scramble,
                             output logic [31:0] bits, output int nbits, output int nbusy,
                             output int nsof, output int ndone, output int qlen);
        bits  = '0;
        nbits = 0;
        nbusy = 0;
        nsof  = 0;
        ndone = 0;
        pat   = p;
        reps  = r;
        gap   = g;
        start = 1'b1;
        tick();
        start = 1'b0;
        qlen  = exp_q.size();
        for (int c = 0; c < 200; c++) begin
            if (!busy) break;
            nbusy++;
            if (dvalid) begin
                bits = {bits[30:0], dout};
                nbits++;
            end
            nsof  += int'(sof);
            ndone += int'(done);
            if (scramble) begin
                pat   = W'($urandom);
                reps  = CW'($urandom);
                gap   = GW'($urandom);
                start = (c % 2 == 0);
            end
            tick();
        end
        start = 1'b0;
        check("frame_terminates", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] bits;
        int nbits, nbusy, nsof, ndone, qlen;

        n_rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        pat   = '0;
        reps  = '0;
        gap   = '0;
        tick();
        checking = 1'b1;
        tick();
        check("reset_outputs", 32'({dout, dvalid, sof, busy, done}), 32'd0);
        n_rst = 1'b1;
        tick();

        // Single frame of the default pattern.
        run_frame(DEF_PAT, 8'd1, 4'd0, 1'b0, bits, nbits, nbusy, nsof, ndone, qlen);
        check("single_bits", bits, 32'h0000_000d);
        check("single_nbits", 32'(nbits), 32'd4);
        check("single_busy", 32'(nbusy), 32'd5);
        check("single_sof", 32'(nsof), 32'd1);
        check("single_done", 32'(ndone), 32'd1);
        tick();

        // Three repetitions with a two-cycle gap.
        run_frame(4'b1101, 8'd3, 4'd2, 1'b0, bits, nbits, nbusy, nsof, ndone, qlen);
        check("rep3_model_len", 32'(qlen), 32'd17);
        check("rep3_bits", bits, 32'h0000_0ddd);
        check("rep3_nbits", 32'(nbits), 32'd12);
        check("rep3_busy", 32'(nbusy), 32'd17);
        check("rep3_sof", 32'(nsof), 32'd3);
        tick();

        // Back-to-back frames.
        run_frame(4'b1101, 8'd2, 4'd0, 1'b0, bits, nbits, nbusy, nsof, ndone, qlen);
        check("b2b_bits", bits, 32'h0000_00dd);
        check("b2b_busy", 32'(nbusy), 32'd9);
        check("b2b_sof", 32'(nsof), 32'd2);
        tick();

        // reps=0 behaves as one repetition.
        run_frame(4'b1101, 8'd0, 4'd3, 1'b0, bits, nbits, nbusy, nsof, ndone, qlen);
        check("rep0_bits", bits, 32'h0000_000d);
        check("rep0_busy", 32'(nbusy), 32'd5);
        tick();

        // Inputs churn and start is pulsed while busy: capture must be unaffected.
        run_frame(4'b1101, 8'd1, 4'd0, 1'b1, bits, nbits, nbusy, nsof, ndone, qlen);
        check("iso_bits", bits, 32'h0000_000d);
        check("iso_busy", 32'(nbusy), 32'd5);
        check("iso_done", 32'(ndone), 32'd1);
        run_frame(4'b1101, 8'd2, 4'd1, 1'b1, bits, nbits, nbusy, nsof, ndone, qlen);
        check("iso2_bits", bits, 32'h0000_00dd);
        check("iso2_busy", 32'(nbusy), 32'd10);
        tick();

        // Abort on the third bit.
        pat   = 4'b1101;
        reps  = 8'd1;
        gap   = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort_third_bit_valid", 32'({dout, dvalid}), 32'b01);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_outputs", 32'({dout, dvalid, sof, busy, done}), 32'd0);
        tick();
        check("abort_no_done", 32'({busy, done}), 32'd0);

        // abort together with start in IDLE.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_idle", 32'(busy), 32'd0);
        tick();

        // Synchronous reset mid-transmission.
        reps  = 8'd3;
        gap   = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_rst = 1'b0;
        tick();
        tick();
        check("midframe_reset", 32'({dout, dvalid, sof, busy, done}), 32'd0);
        n_rst = 1'b1;
        tick();

        // Randomized traffic checked against the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            n_rst = ($urandom_range(0, 59) != 0);
            abort = ($urandom_range(0, 39) == 0);
            start = ($urandom_range(0, 3) == 0);
            pat   = W'($urandom);
            reps  = CW'($urandom_range(0, 3));
            gap   = GW'($urandom_range(0, 3));
            tick();
        end
        n_rst = 1'b1;
        abort = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 25; c++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pattern_tx.md
# pattern_tx

Serial pattern transmitter: on a start request it captures a WIDTH-bit pattern and shifts it out MSB-first on a single-bit line, repeated a programmable number of times with a programmable idle gap between repetitions. It is the source end of the team's serial pattern-detection path. It drives the `din` line of the sequence detectors and serves as their stimulus and loopback generator. Defaults produce the 1101 frame.

## Interface
- `WIDTH`, 4: pattern length in bits, ≥2
- `CNT_W`, 8: width of repeat count
- `GAP_W`, 4: width of gap count
- `clk`  in  1  clock; all logic on rising edge
- `n_rst`  in  1  reset, synchronous, active-low
- `start`  in  1  request; sampled only in IDLE
- `abort`  in  1  stop transmission; forces IDLE on next edge
- `pat`  in  WIDTH  pattern, captured when start accepted (default use 4'b1101)
- `reps`  in  CNT_W  number of transmissions, captured with pat; 0 treated as 1
- `gap`  in  GAP_W  idle cycles between repetitions, captured with pat
- `dout`  out  1  serial data, MSB first
- `dvalid`  out  1  dout carries a pattern bit this cycle
- `sof`  out  1  high with the first (MSB) bit of every repetition
- `busy`  out  1  transmission in progress (SHIFT, GAP, DONE)
- `done`  out  1  one-cycle pulse after final bit of final repetition

## Operation
- All outputs registered; reset (n_rst=0 at an edge) → state IDLE, dout=0, dvalid=0, sof=0, busy=0, done=0, all counters 0.
- States: IDLE, SHIFT, GAP, DONE (binary, 2 bits).
- IDLE: start=1 → load shift reg ← pat, rep_cnt ← max(reps,1), gap_reg ← gap, bit_cnt ← WIDTH-1; go SHIFT.
- SHIFT: dout = shreg MSB, dvalid=1, sof=1 when bit_cnt==WIDTH-1; shift left each cycle, decrement bit_cnt.
  - bit_cnt==0 and rep_cnt==1 → DONE.
  - bit_cnt==0, rep_cnt>1, gap_reg==0 → reload shreg from captured pattern, rep_cnt-1, stay SHIFT (back-to-back frames).
  - bit_cnt==0, rep_cnt>1, gap_reg>0 → GAP, gap_cnt ← gap_reg, rep_cnt-1.
- GAP: dout=0, dvalid=0; after gap_reg cycles, reload shreg and enter SHIFT.
- DONE: done=1, busy=1, dvalid=0 for exactly one cycle → IDLE.
- Captured pattern held in a separate register; pat/reps/gap changes while busy have no effect.
- start while busy (including DONE) ignored, not queued.
- abort=1 in any non-IDLE state → IDLE next edge, outputs to reset values, no done pulse. abort and start together in IDLE → abort wins, stay IDLE.
- n_rst=0 mid-transmission → identical to reset, frame truncated.

## Timing
- start accepted at edge k → first bit (MSB, sof=1) valid in cycle after edge k.
- One bit per cycle; dvalid high WIDTH consecutive cycles per repetition.
- busy high from edge k through DONE cycle; total busy cycles = reps·WIDTH + (reps−1)·gap + 1.
- done in cycle immediately after last data bit; new start accepted earliest at the edge ending the DONE cycle's successor (first IDLE cycle).
- dout=0 whenever dvalid=0.

## Structure
- Package `pattern_tx_pkg`: state localparams (IDLE=0, SHIFT=1, GAP=2, DONE=3), default WIDTH/CNT_W/GAP_W, default pattern 4'b1101.
- One sub-module: `ptx_shreg` — parallel-load, left-shift register with MSB tap, load/shift enables and sync clear. FSM and counters in the top.

## Test plan
- Reset: n_rst=0 for 2 edges mid-SHIFT → all outputs 0 next cycle; state IDLE.
- Single frame: pat=1101, reps=1, gap=0, start at edge k → dout 1,1,0,1 with dvalid=1 cycles k+1..k+4, sof only at k+1, done at k+5, busy k+1..k+5.
- Repeats with gap: pat=1101, reps=3, gap=2 → bits 1101,00,1101,00,1101 (dvalid low in gaps), 3 sof pulses, 17 busy cycles.
- Back-to-back and reps=0: reps=2, gap=0 → 8 contiguous valid bits 11011101; reps=0 → behaves as reps=1.
- Abort/ignore: start during SHIFT ignored; abort at third bit → IDLE next cycle, no done; abort+start together in IDLE → remains IDLE.
- Capture isolation: change pat to 0000 one cycle after start → original 1101 transmitted fully.
